trig_tag_receiver: RTL

//   Receiving end of the trigger-tag word stream sent by the lv1b pipeline to the trigger-tag ADC.

---
 rtl/trig_tag_receiver_pkg.sv | 33 +++
 rtl/trig_tag_receiver_sat_counter.sv | 23 ++
 rtl/trig_tag_receiver.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/trig_tag_receiver_pkg.sv
// Shared frame layout for the trigger-tag word stream.
// Transmitter and receiver both import this package.
package trig_tag_receiver_pkg;

  localparam logic [15:0] HEADER = 16'hEEEE;
  localparam int          NWORDS = 9;

  localparam logic [3:0] W_HDR     = 4'd0;
  localparam logic [3:0] W_ID      = 4'd1;
  localparam logic [3:0] W_VETO_LO = 4'd2;
  localparam logic [3:0] W_VETO_HI = 4'd3;
  localparam logic [3:0] W_TS_LO   = 4'd4;
  localparam logic [3:0] W_TS_HI   = 4'd5;
  localparam logic [3:0] W_INT     = 4'd6;
  localparam logic [3:0] W_FLAGS   = 4'd7;
  localparam logic [3:0] W_ET      = 4'(NWORDS - 1);

  localparam int ID_W       = 10;
  localparam int FIX_LSB    = 10;
  localparam int FIX_W      = 6;
  localparam int RAW_LSB    = 0;
  localparam int SCALED_LSB = 8;
  localparam int NCLUS_LSB  = 0;
  localparam int EXT_LSB    = 4;
  localparam int DELTA_BIT  = 8;
  localparam int PS_BIT     = 9;

  typedef enum logic {
    S_IDLE,
    S_BODY
  } state_t;

endpackage

// File: rtl/trig_tag_receiver_sat_counter.sv
// Saturating event counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/trig_tag_receiver.sv
// Deframes 9-word trigger-tag frames, checks fixed
// fields and event-ID continuity, emits one record per frame.
module trig_tag_receiver
  import trig_tag_receiver_pkg::*;
#(
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_live,
  input  logic [15:0]      in_tag_word,
  output logic             out_valid,
  output logic [9:0]       out_event_id,
  output logic [31:0]      out_veto_raw,
  output logic [31:0]      out_timestamp,
  output logic [7:0]       out_int_raw,
  output logic [7:0]       out_int_scaled,
  output logic [3:0]       out_nclus,
  output logic [3:0]       out_ext,
  output logic             out_delta,
  output logic             out_is_ps,
  output logic [15:0]      out_et_raw,
  output logic [19:0]      frame_cnt,
  output logic [ERR_W-1:0] fmt_err_cnt,
  output logic [ERR_W-1:0] id_err_cnt
);

  state_t state, state_nxt;
  logic [3:0] idx, idx_nxt;
  logic latch, abort, done;
  logic pre_live, live_rise;
  logic [ID_W-1:0] exp_id;

  logic [ID_W-1:0] sh_id;
  logic [15:0] sh_veto_lo, sh_veto_hi;
  logic [15:0] sh_ts_lo, sh_ts_hi;
  logic [15:0] sh_int;
  logic [9:0]  sh_flags;

  logic fix_bad;

  assign live_rise = in_live && !pre_live;
  assign fix_bad = |in_tag_word[FIX_LSB +: FIX_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= W_HDR;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    latch     = 1'b0;
    abort     = 1'b0;
    done      = 1'b0;
    if (!in_live) begin
      state_nxt = S_IDLE;
      idx_nxt   = W_HDR;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_tag_word == HEADER) begin
            state_nxt = S_BODY;
            idx_nxt   = W_ID;
          end
        end
        S_BODY: begin
          // aborting word is dropped, never retried as a header
          if ((idx == W_ID || idx == W_FLAGS) && fix_bad) begin
            abort     = 1'b1;
            state_nxt = S_IDLE;
            idx_nxt   = W_HDR;
          end else if (idx == W_ET) begin
            done      = 1'b1;
            state_nxt = S_IDLE;
            idx_nxt   = W_HDR;
          end else begin
            latch   = 1'b1;
            idx_nxt = idx + 4'd1;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          idx_nxt   = W_HDR;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_id      <= '0;
      sh_veto_lo <= '0;
      sh_veto_hi <= '0;
      sh_ts_lo   <= '0;
      sh_ts_hi   <= '0;
      sh_int     <= '0;
      sh_flags   <= '0;
    end else if (latch) begin
      unique case (idx)
        W_ID:      sh_id      <= in_tag_word[ID_W-1:0];
        W_VETO_LO: sh_veto_lo <= in_tag_word;
        W_VETO_HI: sh_veto_hi <= in_tag_word;
        W_TS_LO:   sh_ts_lo   <= in_tag_word;
        W_TS_HI:   sh_ts_hi   <= in_tag_word;
        W_INT:     sh_int     <= in_tag_word;
        W_FLAGS:   sh_flags   <= in_tag_word[9:0];
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_event_id   <= '0;
      out_veto_raw   <= '0;
      out_timestamp  <= '0;
      out_int_raw    <= '0;
      out_int_scaled <= '0;
      out_nclus      <= '0;
      out_ext        <= '0;
      out_delta      <= 1'b0;
      out_is_ps      <= 1'b0;
      out_et_raw     <= '0;
    end else begin
      out_valid <= done;
      if (done) begin
        out_event_id   <= sh_id;
        out_veto_raw   <= {sh_veto_hi, sh_veto_lo};
        out_timestamp  <= {sh_ts_hi, sh_ts_lo};
        out_int_raw    <= sh_int[RAW_LSB +: 8];
        out_int_scaled <= sh_int[SCALED_LSB +: 8];
        out_nclus      <= sh_flags[NCLUS_LSB +: 4];
        out_ext        <= sh_flags[EXT_LSB +: 4];
        out_delta      <= sh_flags[DELTA_BIT];
        out_is_ps      <= sh_flags[PS_BIT];
        out_et_raw     <= in_tag_word;
      end
    end
  end

  // expected ID resyncs to whatever arrived
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_live  <= 1'b0;
      exp_id    <= '0;
      frame_cnt <= '0;
    end else begin
      pre_live <= in_live;
      if (!in_live) begin
        exp_id <= '0;
      end else if (done) begin
        exp_id <= sh_id + 1'b1;
      end
      if (live_rise) begin
        frame_cnt <= '0;
      end else if (done) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  sat_counter #(.W(ERR_W)) u_fmt_err (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (live_rise),
    .inc   (abort),
    .count (fmt_err_cnt)
  );

  sat_counter #(.W(ERR_W)) u_id_err (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (live_rise),
    .inc   (done && (sh_id != exp_id)),
    .count (id_err_cnt)
  );

endmodule
